// File: rtl/radix2_bf_64.sv
// radix2_bf_64: radix-2 DIF butterfly for the 64-delay stage of a 256-point
// SDF FFT. Drives an external 64-entry delay line and reads its tail back.
// A phase (cnt < 64): incoming samples are parked in the line while the
// differences from the previous block drain out of it.
// B phase (cnt >= 64): the line output pairs with the incoming sample. The
// sum goes out, and the difference goes into the line.
module radix2_bf_64 #(
   parameter int SCALE = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic signed [23:0] din_r,
   input  logic signed [23:0] din_i,
   input  logic signed [23:0] sr_dout_r,
   input  logic signed [23:0] sr_dout_i,
   output logic               sr_in_valid,
   output logic signed [23:0] sr_din_r,
   output logic signed [23:0] sr_din_i,
   output logic               out_valid,
   output logic signed [23:0] dout_r,
   output logic signed [23:0] dout_i,
   output logic        [6:0]  out_idx
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic        blk_live_q, blk_live_d;
   logic        prev_live_q, prev_live_d;
   logic        out_valid_q, out_valid_d;
   logic [23:0] dout_r_q, dout_r_d;
   logic [23:0] dout_i_q, dout_i_d;
   logic [6:0]  out_idx_q, out_idx_d;

   logic        run_s;
   logic        act_s;
   logic        phase_b_s;
   logic [23:0] din_eff_r_s, din_eff_i_s;
   logic [24:0] sum_r_s, sum_i_s, diff_r_s, diff_i_s;
   logic [23:0] sum_r_sc_s, sum_i_sc_s, diff_r_sc_s, diff_i_sc_s;

   // Reduce a 25-bit butterfly result to 24 bits: plain wrap, or floor-halve.
   function automatic logic [23:0] scale_f(input logic [24:0] v);
      if (SCALE != 0) begin
         return v[24:1];
      end else begin
         return v[23:0];
      end
   endfunction

   assign run_s     = (state_q != ST_IDLE);
   assign act_s     = in_valid | run_s;
   assign phase_b_s = cnt_q[6];

   // Gapped cycles inject zero samples; 25-bit sum/difference with sign extension.
   always_comb begin
      din_eff_r_s = in_valid ? din_r : 24'd0;
      din_eff_i_s = in_valid ? din_i : 24'd0;
      sum_r_s     = {sr_dout_r[23], sr_dout_r} + {din_eff_r_s[23], din_eff_r_s};
      sum_i_s     = {sr_dout_i[23], sr_dout_i} + {din_eff_i_s[23], din_eff_i_s};
      diff_r_s    = {sr_dout_r[23], sr_dout_r} - {din_eff_r_s[23], din_eff_r_s};
      diff_i_s    = {sr_dout_i[23], sr_dout_i} - {din_eff_i_s[23], din_eff_i_s};
      sum_r_sc_s  = scale_f(sum_r_s);
      sum_i_sc_s  = scale_f(sum_i_s);
      diff_r_sc_s = scale_f(diff_r_s);
      diff_i_sc_s = scale_f(diff_i_s);
   end

   // Delay-line feed: raw sample in A phase, scaled difference in B phase.
   always_comb begin
      sr_in_valid = rst_n & act_s;
      if (phase_b_s) begin
         sr_din_r = diff_r_sc_s;
         sr_din_i = diff_i_sc_s;
      end else begin
         sr_din_r = din_eff_r_s;
         sr_din_i = din_eff_i_s;
      end
   end

   // Next-state: counter, block liveness, phase-dependent output selection.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      blk_live_d  = blk_live_q;
      prev_live_d = prev_live_q;
      out_valid_d = 1'b0;
      dout_r_d    = dout_r_q;
      dout_i_d    = dout_i_q;
      out_idx_d   = out_idx_q;
      if (act_s) begin
         cnt_d = cnt_q + 7'd1;
         if (phase_b_s) begin
            out_valid_d = blk_live_q;
            dout_r_d    = sum_r_sc_s;
            dout_i_d    = sum_i_sc_s;
            out_idx_d   = {1'b0, cnt_q[5:0]};
            if (cnt_q == 7'd127) begin
               prev_live_d = blk_live_q;
               blk_live_d  = 1'b0;
            end else begin
               prev_live_d = prev_live_q;
            end
         end else begin
            // The line tail holds the difference stored one block ago.
            out_valid_d = prev_live_q;
            dout_r_d    = sr_dout_r;
            dout_i_d    = sr_dout_i;
            out_idx_d   = {1'b1, cnt_q[5:0]};
            if (in_valid) begin
               blk_live_d = 1'b1;
            end else begin
               blk_live_d = blk_live_q;
            end
         end
      end else begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_FILL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (act_s && (cnt_d == 7'd64)) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 7'd0;
         blk_live_q  <= 1'b0;
         prev_live_q <= 1'b0;
         out_valid_q <= 1'b0;
         dout_r_q    <= 24'd0;
         dout_i_q    <= 24'd0;
         out_idx_q   <= 7'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         blk_live_q  <= blk_live_d;
         prev_live_q <= prev_live_d;
         out_valid_q <= out_valid_d;
         dout_r_q    <= dout_r_d;
         dout_i_q    <= dout_i_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout_r    = dout_r_q;
   assign dout_i    = dout_i_q;
   assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_radix2_bf_64.sv
// Directed bench for radix2_bf_64. Two instances (SCALE=0 and SCALE=1) share
// the input stream, and each one has its own behavioural 64-entry delay line.
module tb_radix2_bf_64;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic signed [23:0] din_r, din_i;

   logic               sr_v0, sr_v1;
   logic signed [23:0] sr_din_r0, sr_din_i0, sr_din_r1, sr_din_i1;
   logic signed [23:0] sr_dout_r0, sr_dout_i0, sr_dout_r1, sr_dout_i1;
   logic               ov0, ov1;
   logic signed [23:0] dr0, di0, dr1, di1;
   logic [6:0]         idx0, idx1;

   logic [23:0] dl_r0 [64];
   logic [23:0] dl_i0 [64];
   logic [23:0] dl_r1 [64];
   logic [23:0] dl_i1 [64];

   int pass_cnt;
   int chk_cnt;

   radix2_bf_64 #(.SCALE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
      .sr_dout_r(sr_dout_r0), .sr_dout_i(sr_dout_i0), .sr_in_valid(sr_v0),
      .sr_din_r(sr_din_r0), .sr_din_i(sr_din_i0), .out_valid(ov0),
      .dout_r(dr0), .dout_i(di0), .out_idx(idx0)
   );

   radix2_bf_64 #(.SCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
      .sr_dout_r(sr_dout_r1), .sr_dout_i(sr_dout_i1), .sr_in_valid(sr_v1),
      .sr_din_r(sr_din_r1), .sr_din_i(sr_din_i1), .out_valid(ov1),
      .dout_r(dr1), .dout_i(di1), .out_idx(idx1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign sr_dout_r0 = dl_r0[63];
   assign sr_dout_i0 = dl_i0[63];
   assign sr_dout_r1 = dl_r1[63];
   assign sr_dout_i1 = dl_i1[63];

   // Behavioural shift_64 models: synchronous reset, shift on enable.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 64; k++) begin
            dl_r0[k] <= 24'd0; dl_i0[k] <= 24'd0;
            dl_r1[k] <= 24'd0; dl_i1[k] <= 24'd0;
         end
      end else begin
         if (sr_v0) begin
            for (int k = 63; k > 0; k--) begin
               dl_r0[k] <= dl_r0[k-1]; dl_i0[k] <= dl_i0[k-1];
            end
            dl_r0[0] <= sr_din_r0; dl_i0[0] <= sr_din_i0;
         end
         if (sr_v1) begin
            for (int k = 63; k > 0; k--) begin
               dl_r1[k] <= dl_r1[k-1]; dl_i1[k] <= dl_i1[k-1];
            end
            dl_r1[0] <= sr_din_r1; dl_i1[0] <= sr_din_i1;
         end
      end
   end

   task automatic drive(input logic v, input logic [23:0] r, input logic [23:0] i);
      in_valid = v;
      din_r    = r;
      din_i    = i;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 24'd0, 24'd0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 24'd7, 24'd7);
      drive(1'b1, 24'd7, 24'd7);
      chk_cnt++;
      if ({ov0, dr0, di0, idx0} !== {1'b0, 24'd0, 24'd0, 7'd0}) begin
         $display("FAIL reset_outputs: got v=%0b r=%0d i=%0d idx=%0d, want 0/0/0/0", ov0, dr0, di0, idx0);
      end else pass_cnt++;
      chk_cnt++;
      if (sr_v0 !== 1'b0) begin
         $display("FAIL reset_sr_in_valid: got %0b want 0", sr_v0);
      end else pass_cnt++;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk_cnt++;
      if (sr_v0 !== 1'b0) begin
         $display("FAIL idle_sr_in_valid: got %0b want 0", sr_v0);
      end else pass_cnt++;
      in_valid = 1'b1;
      din_r    = 24'h123456;
      din_i    = 24'hABCDEF;
      #1;
      chk_cnt++;
      if ({sr_v0, sr_din_r0, sr_din_i0} !== {1'b1, 24'h123456, 24'hABCDEF}) begin
         $display("FAIL comb_sr_din: got v=%0b r=%h i=%h, want 1/123456/abcdef", sr_v0, sr_din_r0, sr_din_i0);
      end else pass_cnt++;
      do_reset();
   endtask

   // One ramp block then idle; used both standalone and after a mid-block reset.
   task automatic ramp_body(input string nm, input logic imag);
      logic [23:0] er, ei, s;
      for (int n = 0; n < 128; n++) begin
         s = 24'(-n);
         if (imag) drive(1'b1, 24'd0, s);
         else      drive(1'b1, 24'(n), 24'd0);
         chk_cnt++;
         if (n < 64) begin
            if (ov0 !== 1'b0) begin
               $display("FAIL %s_fill n=%0d: got valid %0b want 0", nm, n, ov0);
            end else pass_cnt++;
         end else begin
            er = imag ? 24'd0 : 24'(2*(n-64)+64);
            ei = imag ? 24'(-(2*(n-64)+64)) : 24'd0;
            if ({ov0, dr0, di0, idx0} !== {1'b1, er, ei, 7'(n-64)}) begin
               $display("FAIL %s_sum n=%0d: got v=%0b r=%0d i=%0d idx=%0d, want 1/%0d/%0d/%0d",
                        nm, n, ov0, dr0, di0, idx0, $signed(er), $signed(ei), n-64);
            end else pass_cnt++;
         end
      end
      er = imag ? 24'd0 : 24'(-64);
      ei = imag ? 24'd64 : 24'd0;
      for (int k = 0; k < 64; k++) begin
         drive(1'b0, 24'd0, 24'd0);
         chk_cnt++;
         if ({ov0, dr0, di0, idx0} !== {1'b1, er, ei, 7'(64+k)}) begin
            $display("FAIL %s_diff k=%0d: got v=%0b r=%0d i=%0d idx=%0d, want 1/%0d/%0d/%0d",
                     nm, k, ov0, dr0, di0, idx0, $signed(er), $signed(ei), 64+k);
         end else pass_cnt++;
      end
      for (int k = 0; k < 70; k++) begin
         drive(1'b0, 24'd0, 24'd0);
         chk_cnt++;
         if (ov0 !== 1'b0) begin
            $display("FAIL %s_tail k=%0d: got valid %0b want 0", nm, k, ov0);
         end else pass_cnt++;
      end
   endtask

   task automatic test_ramp();
      do_reset();
      ramp_body("ramp", 1'b0);
   endtask

   task automatic test_imag();
      do_reset();
      ramp_body("imag", 1'b1);
   endtask

   task automatic test_overflow();
      logic [23:0] r;
      do_reset();
      for (int n = 0; n < 128; n++) begin
         r = (n == 0) ? 24'h7FFFFF : ((n == 64) ? 24'h000001 : 24'd0);
         drive(1'b1, r, 24'd0);
         if (n == 64) begin
            chk_cnt++;
            if ({ov0, dr0, idx0} !== {1'b1, 24'h800000, 7'd0}) begin
               $display("FAIL ovf_sum_s0: got v=%0b r=%h idx=%0d, want 1/800000/0", ov0, dr0, idx0);
            end else pass_cnt++;
            chk_cnt++;
            if ({ov1, dr1, di1, idx1} !== {1'b1, 24'h400000, 24'd0, 7'd0}) begin
               $display("FAIL ovf_sum_s1: got v=%0b r=%h i=%h idx=%0d, want 1/400000/0/0", ov1, dr1, di1, idx1);
            end else pass_cnt++;
         end
      end
      drive(1'b0, 24'd0, 24'd0);
      chk_cnt++;
      if ({ov0, dr0, idx0} !== {1'b1, 24'h7FFFFE, 7'd64}) begin
         $display("FAIL ovf_diff_s0: got v=%0b r=%h idx=%0d, want 1/7ffffe/64", ov0, dr0, idx0);
      end else pass_cnt++;
      chk_cnt++;
      if ({ov1, dr1, di1, idx1} !== {1'b1, 24'h3FFFFF, 24'd0, 7'd64}) begin
         $display("FAIL ovf_diff_s1: got v=%0b r=%h i=%h idx=%0d, want 1/3fffff/0/64", ov1, dr1, di1, idx1);
      end else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic        v, ev;
      logic [23:0] r, er;
      logic [6:0]  ei;
      int          blk, pos;
      do_reset();
      for (int c = 0; c < 384; c++) begin
         blk = c / 128;
         pos = c % 128;
         v   = (blk < 2);
         r   = (blk == 0) ? 24'd5 : ((blk == 1) ? 24'd3 : 24'd0);
         drive(v, r, 24'd0);
         ev = 1'b1;
         er = 24'd0;
         ei = (pos < 64) ? 7'(64 + pos) : 7'(pos - 64);
         if (pos >= 64) er = (blk == 0) ? 24'd10 : 24'd6;
         if ((blk == 0 && pos < 64) || (blk == 2 && pos >= 64)) ev = 1'b0;
         chk_cnt++;
         if (!ev) begin
            if (ov0 !== 1'b0) begin
               $display("FAIL b2b_idle c=%0d: got valid %0b want 0", c, ov0);
            end else pass_cnt++;
         end else if ({ov0, dr0, di0, idx0} !== {1'b1, er, 24'd0, ei}) begin
            $display("FAIL b2b c=%0d: got v=%0b r=%0d i=%0d idx=%0d, want 1/%0d/0/%0d",
                     c, ov0, dr0, di0, idx0, er, ei);
         end else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int n = 0; n < 70; n++) drive(1'b1, 24'(n), 24'd0);
      chk_cnt++;
      if ({ov0, dr0, idx0} !== {1'b1, 24'd74, 7'd5}) begin
         $display("FAIL mid_pre: got v=%0b r=%0d idx=%0d, want 1/74/5", ov0, dr0, idx0);
      end else pass_cnt++;
      rst_n = 1'b0;
      drive(1'b1, 24'd70, 24'd0);
      rst_n = 1'b1;
      chk_cnt++;
      if ({ov0, dr0, di0, idx0} !== {1'b0, 24'd0, 24'd0, 7'd0}) begin
         $display("FAIL mid_reset: got v=%0b r=%0d i=%0d idx=%0d, want 0/0/0/0", ov0, dr0, di0, idx0);
      end else pass_cnt++;
      ramp_body("mid", 1'b0);
   endtask

   // Sample 10 is dropped; with the stream indexed by cnt, pair j=10 is 0 and 74.
   task automatic test_gap();
      do_reset();
      for (int n = 0; n < 128; n++) begin
         if (n == 10) drive(1'b0, 24'd999, 24'd0);
         else         drive(1'b1, 24'(n), 24'd0);
         if (n == 73) begin
            chk_cnt++;
            if ({ov0, dr0, idx0} !== {1'b1, 24'd82, 7'd9}) begin
               $display("FAIL gap_sum9: got v=%0b r=%0d idx=%0d, want 1/82/9", ov0, dr0, idx0);
            end else pass_cnt++;
         end
         if (n == 74) begin
            chk_cnt++;
            if ({ov0, dr0, idx0} !== {1'b1, 24'd74, 7'd10}) begin
               $display("FAIL gap_sum10: got v=%0b r=%0d idx=%0d, want 1/74/10", ov0, dr0, idx0);
            end else pass_cnt++;
         end
      end
      for (int k = 0; k < 11; k++) begin
         drive(1'b0, 24'd0, 24'd0);
         if (k == 10) begin
            chk_cnt++;
            if ({ov0, dr0, idx0} !== {1'b1, 24'(-74), 7'd74}) begin
               $display("FAIL gap_diff10: got v=%0b r=%0d idx=%0d, want 1/-74/74", ov0, dr0, idx0);
            end else pass_cnt++;
         end
      end
   endtask

   initial begin
      pass_cnt = 0;
      chk_cnt  = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      din_r    = 24'd0;
      din_i    = 24'd0;
      test_reset();
      test_ramp();
      test_imag();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_gap();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
